calcu_arbitro: RTL and testbench

Two-port arbiter and sequencer for the shared `Calcu` ALU. Accepts operation requests (operands plus opcode) from two requesters over valid/ready handshakes, grants the ALU round-robin, and registers operands. It returns the registered result, flags and error status on a single response channel tagged with the requester id. It sits between the control logic and the single combinational `Calcu` instance, so the ALU is never driven by two sources at once.

---
 rtl/calcu_pkg.sv | 29 ++
 rtl/calcu_arbitro_calcu.sv | 61 ++++++
 rtl/calcu_arbitro.sv | 132 +++++++++++++
 tb/tb_calcu_arbitro.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcu_pkg.sv
// Shared types and constants for the Calcu ALU and its two-port arbiter.
// Opcodes above OP_LAST are illegal and are reported as errors by the arbiter.
package calcu_pkg;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    SUB    = 4'd1,
    MUL    = 4'd2,
    MOD    = 4'd3,
    DIV    = 4'd4,
    AND_OP = 4'd5,
    OR_OP  = 4'd6,
    XOR_OP = 4'd7,
    LSHIFT = 4'd8,
    RSHIFT = 4'd9
  } opcode_t;

  localparam logic [3:0] OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;

endpackage

// File: rtl/calcu_arbitro_calcu.sv
// Combinational Calcu ALU shared behind the arbiter.
// Flags are {zero, carry/borrow/mul-overflow, negative, signed overflow}; illegal opcodes give zero flags.
module Calcu
  import calcu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] salida,
  output logic [3:0]   flags
);

  logic [N:0]     w_sum;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_res;
  logic           w_carry;
  logic           w_ovf;
  logic           w_legal;

  always_comb begin
    w_sum   = '0;
    w_prod  = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_legal = 1'b1;
    case (op)
      ADD: begin
        w_sum   = {1'b0, a} + {1'b0, b};
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_ovf   = (a[N-1] == b[N-1]) && (w_res[N-1] != a[N-1]);
      end
      SUB: begin
        w_sum   = {1'b0, a} - {1'b0, b};
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_ovf   = (a[N-1] != b[N-1]) && (w_res[N-1] != a[N-1]);
      end
      MUL: begin
        w_prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        w_res   = w_prod[N-1:0];
        w_carry = |w_prod[2*N-1:N];
      end
      // A zero divisor yields 0 here; the arbiter flags it and discards the result.
      MOD:    if (b != '0) w_res = a % b;
      DIV:    if (b != '0) w_res = a / b;
      AND_OP: w_res = a & b;
      OR_OP:  w_res = a | b;
      XOR_OP: w_res = a ^ b;
      LSHIFT: w_res = a << b;
      RSHIFT: w_res = a >> b;
      default: w_legal = 1'b0;
    endcase
    salida = w_res;
    flags  = w_legal ? {(w_res == '0), w_carry, w_res[N-1], w_ovf} : 4'b0000;
  end

endmodule

// File: rtl/calcu_arbitro.sv
// Round-robin arbiter/sequencer giving two requesters turns on one shared Calcu ALU.
// Each request runs IDLE -> EXEC -> RESP; responses carry the id of the requester served.
module calcu_arbitro
  import calcu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [3:0]   req_op0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_op1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic         rsp_id,
  output logic         busy
);

  state_t       r_state;
  state_t       w_nextState;
  logic         r_prio;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [3:0]   r_op;
  logic         r_id;
  logic [N-1:0] r_rspData;
  logic [3:0]   r_rspFlags;
  logic         r_rspErr;
  logic         r_rspId;
  logic [1:0]   w_grant;
  logic [N-1:0] w_salida;
  logic [3:0]   w_flags;
  logic         w_err;

  Calcu #(.N(N)) u_calcu (
    .a      (r_a),
    .b      (r_b),
    .op     (r_op),
    .salida (w_salida),
    .flags  (w_flags)
  );

  // On contention r_prio names the requester that was passed over last time.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == IDLE) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign w_err     = (r_op > OP_LAST) || (((r_op == MOD) || (r_op == DIV)) && (r_b == '0));

  always_comb begin
    w_nextState = r_state;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (|w_grant) w_nextState = EXEC;
      end
      EXEC: w_nextState = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_id   <= 1'b0;
      r_prio <= 1'b0;
    end else if (|w_grant) begin
      r_a    <= w_grant[1] ? req_a1  : req_a0;
      r_b    <= w_grant[1] ? req_b1  : req_b0;
      r_op   <= w_grant[1] ? req_op1 : req_op0;
      r_id   <= w_grant[1];
      r_prio <= ~w_grant[1];
    end
  end

  // Response registers load once per request, at the end of EXEC, and then hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspData  <= '0;
      r_rspFlags <= '0;
      r_rspErr   <= ERR_NONE;
      r_rspId    <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rspId <= r_id;
      if (w_err) begin
        r_rspData  <= '0;
        r_rspFlags <= '0;
        r_rspErr   <= ERR_SET;
      end else begin
        r_rspData  <= w_salida;
        r_rspFlags <= w_flags;
        r_rspErr   <= ERR_NONE;
      end
    end
  end

  assign rsp_data  = r_rspData;
  assign rsp_flags = r_rspFlags;
  assign rsp_err   = r_rspErr;
  assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_calcu_arbitro.sv
// Scoreboard bench for calcu_arbitro: a grant/ALU reference model predicts every response,
// and a negedge monitor checks handshakes, latency, hold-off, stability and response contents.
module tb_calcu_arbitro;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reqValid0 = 1'b0;
  logic         reqValid1 = 1'b0;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [3:0]   req_op0 = '0, req_op1 = '0;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic         rsp_id;
  logic         busy;

  logic randMode = 1'b0;
  logic forcedReady = 1'b1;
  logic randReady = 1'b1;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] data;
    logic [3:0] flags;
    logic       err;
    logic       id;
  } rsp_t;

  rsp_t expQ[$];
  logic modelIdle = 1'b1;
  logic modelPrio = 1'b0;
  int   cyc = 0;

  assign req_valid = {reqValid1, reqValid0};
  assign rsp_ready = randMode ? randReady : forcedReady;

  always #5 clk = ~clk;

  calcu_arbitro #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op0   (req_op0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Random consumer back-pressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    randReady = ($urandom % 4) != 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the opcode table evaluated with plain integer arithmetic.
  function automatic rsp_t model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input logic id);
    rsp_t r;
    int ai = int'(a);
    int bi = int'(b);
    int sa = (ai > 7) ? ai - 16 : ai;
    int sb = (bi > 7) ? bi - 16 : bi;
    int v = 0;
    int s = 0;
    logic c = 1'b0;
    logic ov = 1'b0;
    r.id = id;
    r.err = 1'b0;
    r.data = 4'h0;
    r.flags = 4'h0;
    case (op)
      4'd0: begin v = ai + bi; c = (v > 15); s = sa + sb; ov = (s > 7) || (s < -8); end
      4'd1: begin v = ai - bi; c = (ai < bi); s = sa - sb; ov = (s > 7) || (s < -8); end
      4'd2: begin v = ai * bi; c = (v > 15); end
      4'd3: if (bi == 0) r.err = 1'b1; else v = ai % bi;
      4'd4: if (bi == 0) r.err = 1'b1; else v = ai / bi;
      4'd5: v = ai & bi;
      4'd6: v = ai | bi;
      4'd7: v = ai ^ bi;
      4'd8: v = ai << bi;
      4'd9: v = ai >> bi;
      default: r.err = 1'b1;
    endcase
    if (!r.err) begin
      r.data = v[3:0];
      r.flags = {(r.data == 4'h0), c, r.data[3], ov};
    end
    return r;
  endfunction

  // Monitor: predicts grants from the round-robin rule and pops the scoreboard on each response handshake.
  initial begin
    rsp_t exp;
    rsp_t got;
    rsp_t held;
    logic haveHeld = 1'b0;
    logic [1:0] expGrant;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        modelIdle = 1'b1;
        modelPrio = 1'b0;
        haveHeld = 1'b0;
        cyc = 0;
      end else begin
        if (!modelIdle) cyc++;
        expGrant = 2'b00;
        if (modelIdle) begin
          case (req_valid)
            2'b01:   expGrant = 2'b01;
            2'b10:   expGrant = 2'b10;
            2'b11:   expGrant = modelPrio ? 2'b10 : 2'b01;
            default: expGrant = 2'b00;
          endcase
        end
        checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
        checkOutput("busy", 32'(busy), 32'(!modelIdle));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(!modelIdle && cyc >= 2));
        got.data = rsp_data;
        got.flags = rsp_flags;
        got.err = rsp_err;
        got.id = rsp_id;
        if (rsp_valid && haveHeld) begin
          checkOutput("rsp_stable", {rsp_data, rsp_flags, 2'b00, rsp_err, rsp_id},
                      {held.data, held.flags, 2'b00, held.err, held.id});
        end
        if (rsp_valid && !rsp_ready) begin
          held = got;
          haveHeld = 1'b1;
        end
        if (rsp_valid && rsp_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            exp = expQ.pop_front();
            checkOutput("rsp_data", 32'(rsp_data), 32'(exp.data));
            checkOutput("rsp_flags", 32'(rsp_flags), 32'(exp.flags));
            checkOutput("rsp_err", 32'(rsp_err), 32'(exp.err));
            checkOutput("rsp_id", 32'(rsp_id), 32'(exp.id));
          end
          modelIdle = 1'b1;
          haveHeld = 1'b0;
          cyc = 0;
        end
        if (cyc > 60) begin
          checkOutput("rsp_timeout", 32'd1, 32'd0);
          modelIdle = 1'b1;
          cyc = 0;
        end
        if (expGrant != 2'b00) begin
          if (expGrant[1]) expQ.push_back(model(req_a1, req_b1, req_op1, 1'b1));
          else             expQ.push_back(model(req_a0, req_b0, req_op0, 1'b0));
          modelPrio = !expGrant[1];
          modelIdle = 1'b0;
          cyc = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int cnt = 0;
    @(posedge clk);
    #1;
    if (i == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; reqValid0 = 1'b1; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; reqValid1 = 1'b1; end
    do begin
      @(negedge clk);
      cnt++;
    end while (!(req_ready[i] && rst_n) && cnt < 300);
    if (cnt >= 300) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (i == 0) reqValid0 = 1'b0;
    else        reqValid1 = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (!(modelIdle && expQ.size() == 0) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) checkOutput("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic waitRspValid();
    int cnt = 0;
    while (!rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) checkOutput("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic randomBurst(input int i, input int n);
    logic [3:0] a, b, op;
    repeat (n) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = 4'($urandom);
      b = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
      op = (($urandom % 8) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      applyStimulus(i, a, b, op);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;

    applyStimulus(0, 4'd1, 4'd1, 4'd0);
    drain();

    fork
      applyStimulus(0, 4'd4, 4'd1, 4'd0);
      applyStimulus(1, 4'd2, 4'd3, 4'd7);
    join
    drain();
    fork
      applyStimulus(0, 4'd4, 4'd1, 4'd0);
      applyStimulus(1, 4'd2, 4'd3, 4'd7);
    join
    drain();

    applyStimulus(1, 4'd4, 4'd0, 4'd4);
    applyStimulus(1, 4'd4, 4'd0, 4'd3);
    drain();
    applyStimulus(0, 4'd5, 4'd3, 4'd12);
    drain();

    // Consumer stalls in RESP while requester 1 waits.
    forcedReady = 1'b0;
    fork
      applyStimulus(0, 4'd3, 4'd2, 4'd2);
      begin waitRspValid(); applyStimulus(1, 4'd5, 4'd5, 4'd6); end
      begin waitRspValid(); repeat (3) @(posedge clk); #1; forcedReady = 1'b1; end
    join
    drain();

    // Reset pulse during EXEC aborts the request without a response.
    @(posedge clk);
    #1;
    req_a0 = 4'd7; req_b0 = 4'd2; req_op0 = 4'd0; reqValid0 = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reqValid0 = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("abort_rsp_id", 32'(rsp_id), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 4'd1, 4'd1, 4'd1);
    drain();

    randMode = 1'b1;
    repeat (30) begin
      fork
        randomBurst(0, 4);
        randomBurst(1, 4);
      join
    end
    randMode = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
